// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: fetch FSM states, the
// {pc, inst} entry carried by both fetch queues, and the PC step helper.
package fetch_unit_pkg;

    localparam int XLEN       = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INST_BYTES);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a flush that wins over push.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  fetch_entry_t               entry_i,
    input  logic                       pop_i,
    output fetch_entry_t               head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited imem requests, in-order
// response buffering and redirect flush. FETCH_ALIGN_CHECK_EN enables misaligned-redirect faulting.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            fetch_fault,
    output fetch_state_e    dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            fault_q, fault_d;
    logic            started_q;

    logic [XLEN-1:0] redirect_tgt;
    logic            redirect_bad;
    logic            req_allowed, resp_drop;
    logic            req_fire, resp_counted, resp_keep, inst_fire, credit_ok;
    logic [CW:0]     used_slots;
    logic [CW-1:0]   drop_on_redirect;
    logic [CW-1:0]   inflight_cnt, ififo_cnt;
    fetch_entry_t    inflight_entry, inflight_head, ififo_entry, ififo_head;
    logic            unused_bits;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_tgt = redirect_pc;
    assign redirect_bad = (redirect_pc[1:0] != 2'b00);
`else
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_bad = 1'b0;
`endif

    // Valid/ready: a transfer happens in any cycle where both valid and ready
    // are high; valid never waits on ready of its own channel.
    assign inst_valid = (ififo_cnt != '0);
    assign inst_fire  = inst_valid && inst_ready;

    // An instruction leaving this cycle frees a slot, which keeps one fetch per cycle.
    assign used_slots = {1'b0, outstanding_q} + {1'b0, ififo_cnt} - (CW+1)'(inst_fire);
    assign credit_ok  = used_slots < (CW+1)'(DEPTH);

    assign imem_req_valid = started_q && req_allowed && credit_ok && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses arriving with nothing tracked (stale after a reset) are ignored.
    assign resp_counted     = imem_resp_valid && (outstanding_q != '0);
    assign resp_keep        = resp_counted && !resp_drop && !redirect_valid;
    assign drop_on_redirect = outstanding_q - CW'(resp_counted);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fault_q       <= 1'b0;
            started_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fault_q       <= fault_d;
            started_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        fault_d    = fault_q;
        if (redirect_valid) begin
            drop_cnt_d = drop_on_redirect;
            if (redirect_bad) begin
                state_d = HALT;
                fault_d = 1'b1;
            end else begin
                fault_d = 1'b0;
                state_d = (drop_on_redirect != '0) ? DRAIN : RUN;
            end
        end else begin
            case (state_q)
                DRAIN: begin
                    if (resp_counted) begin
                        drop_cnt_d = drop_cnt_q - 1'b1;
                        if (drop_cnt_q == CW'(1)) state_d = RUN;
                    end
                end
                HALT: begin
                    if (resp_counted && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_allowed = 1'b0;
        resp_drop   = 1'b0;
        unique case (state_q)
            RUN:     req_allowed = 1'b1;
            DRAIN:   resp_drop   = 1'b1;
            HALT:    resp_drop   = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_counted);
        if (redirect_valid)  pc_d = redirect_tgt;
        else if (req_fire)   pc_d = next_pc(pc_q);
    end

    assign inflight_entry = '{pc: pc_q, inst: '0};
    assign ififo_entry    = '{pc: inflight_head.pc, inst: imem_resp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_inflight (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (redirect_valid),
        .push_i  (req_fire),
        .entry_i (inflight_entry),
        .pop_i   (resp_keep),
        .head_o  (inflight_head),
        .count_o (inflight_cnt)
    );

    fetch_fifo #(.DEPTH(DEPTH)) u_inst_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .flush_i (redirect_valid),
        .push_i  (resp_keep),
        .entry_i (ififo_entry),
        .pop_i   (inst_fire),
        .head_o  (ififo_head),
        .count_o (ififo_cnt)
    );

    assign inst_data   = ififo_head.inst;
    assign inst_pc     = ififo_head.pc;
    assign fetch_fault = fault_q;
    assign dbg_state   = state_q;

    assign unused_bits = ^{inflight_head.inst, inflight_cnt, redirect_pc[1:0]};

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. It owns the program counter, issues word fetches to instruction memory over a valid/ready request channel, and accepts in-order responses. Fetched words are buffered in a small FIFO and presented to the decoder with their PC. A redirect from the branch/jump resolution logic flushes wrong-path work.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- DEPTH, 2, instruction FIFO entries; also the maximum number of outstanding requests
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  word address (bits [1:0] always 0)
- imem_resp_valid  input  1  response valid; in order, one per accepted request, latency ≥1 cycle, no backpressure
- imem_resp_data  input  32  instruction word
- redirect_valid  input  1  taken branch/jump; single-cycle pulse
- redirect_pc  input  32  redirect target
- inst_valid  output  1  instruction available to the decoder
- inst_ready  input  1  decoder consumes the instruction
- inst_data  output  32  instruction
- inst_pc  output  32  PC of inst_data
- fetch_fault  output  1  misaligned-target fault; tied to 0 without the macro

## Operation
- **State machine:** RUN, DRAIN, HALT.
- **Credit rule:** request allowed iff (outstanding + fifo_count) < DEPTH. imem_req_valid = credit available && state==RUN && !redirect_valid.
- **Request handshake:** on imem_req_valid && imem_req_ready, push pc into the in-flight PC queue, set pc ← pc+4 (mod 2^32), increment outstanding.
- **Response:** pop the in-flight PC and push {pc, data} into the FIFO. In DRAIN, instead discard the response and decrement drop_cnt.
- **Output:** inst_valid = FIFO non-empty. inst_data/inst_pc are the FIFO head. Pop on inst_valid && inst_ready.
- **Redirect:**
  - pc ← redirect_pc; FIFO and in-flight PC queue are flushed.
  - drop_cnt ← outstanding − (imem_resp_valid ? 1 : 0).
  - Next state is DRAIN if drop_cnt ≠ 0, else RUN.
  - A response arriving in the redirect cycle is discarded.
  - An inst handshake in the redirect cycle still counts as consumed; killing it is the consumer's responsibility.
- **DRAIN:** no requests issued. Return to RUN in the cycle after drop_cnt reaches 0.
- **Redirect during DRAIN:** drop_cnt recomputed by the same formula; the state stays DRAIN unless that result is 0.
- **HALT:** entered only via the macro feature. No requests; FIFO drains normally. Left only by reset or a valid (aligned) redirect.

## Timing
- **Reset values:** pc=RESET_PC, state=RUN, counts 0. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, fetch_fault=0.
- **First request:** imem_req_valid rises in the first clk edge after rstn deasserts.
- **Response to decoder:** response in cycle N → inst_valid in cycle N+1 (registered FIFO, no bypass).
- **Redirect to fetch:** redirect in cycle N → first request to the target in cycle N+1 if drop_cnt=0.
- **Steady state:** DEPTH=2 with 1-cycle memory latency gives one instruction per cycle.
- **Full FIFO:** with the FIFO full and inst_ready low, no request is issued; the credit rule guarantees responses never overflow.
- **Simultaneous push and pop:** allowed when the FIFO is full.
- **Reset mid-operation:** all state cleared immediately; in-flight responses after reset are not tracked. Memory must be reset with the same rstn.

## Configuration
- **FETCH_ALIGN_CHECK_EN defined:**
  - A redirect_pc with [1:0]≠0 sets fetch_fault (sticky) and enters HALT instead of RUN/DRAIN.
  - Outstanding responses are still dropped.
  - fetch_fault clears on reset or on an aligned redirect.
- **Not defined:** redirect_pc[1:0] is forced to 0 and fetch_fault is constant 0.

## Structure
- Shared package carries:
  - fetch state enum {RUN, DRAIN, HALT}
  - XLEN=32
  - INST_BYTES=4
  - typedef fetch_entry_t {pc, inst}
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with flush input.
  - Instantiated twice: the in-flight PC queue (pc field only used) and the instruction FIFO.

## Test plan
- **Reset and stream:** reset, memory with 1-cycle latency and ready=1, inst_ready=1 → requests at 0,4,8,…; inst_pc 0,4,8 on consecutive cycles starting two cycles after the first request.
- **Backpressure:** inst_ready=0 for 10 cycles → at most 2 requests issued, FIFO holds PCs 0,4. On release, both are delivered in order with no loss.
- **Redirect with responses in flight:** 3-cycle latency, 2 requests outstanding, redirect to 0x100 → both stale responses dropped, next inst_pc=0x100, no stale word reaches the decoder.
- **Simultaneous events:** redirect in the same cycle as a response and an inst handshake → response discarded, drop_cnt=outstanding−1, next delivered PC=redirect target.
- **Wrap-around:** redirect to 0xFFFF_FFFC → next request addresses 0xFFFF_FFFC then 0x0000_0000.
- **Misaligned redirect (macro on):** redirect to 0x102 → fetch_fault=1, no requests. A later redirect to 0x200 clears the fault and fetch resumes at 0x200. With the macro off, redirect to 0x102 fetches from 0x100.
